// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_arbiter
//  Purpose  : Round-robin arbitration of ALU and LSU writebacks onto the
//             single register-file write port, with a RAW pending-write mask.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_valid,
  output logic              p0_ready,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [2:0]        p0_mode,
  input  logic [DATA_W-1:0] p0_data,
  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [2:0]        p1_mode,
  input  logic [DATA_W-1:0] p1_data,
  output logic [2:0]        we3,
  output logic [ADDR_W-1:0] a3,
  output logic [DATA_W-1:0] wd3,
  output logic [31:0]       pend_mask,
  output logic              last_grant
);

  localparam logic [2:0] c_MODE_NONE = 3'b000;
  localparam logic [2:0] c_MODE_W32  = 3'b101;

  logic              r_full0, r_full1;
  logic [ADDR_W-1:0] r_addr0, r_addr1;
  logic [2:0]        r_mode0, r_mode1;
  logic [DATA_W-1:0] r_data0, r_data1;
  logic              r_last;
  logic [2:0]        r_we3;
  logic [ADDR_W-1:0] r_a3;
  logic [DATA_W-1:0] r_wd3;

  logic              w_g0, w_g1;
  logic              w_acc0, w_acc1;
  logic              w_drop0, w_drop1;
  logic [31:0]       w_pend;

  // Entries with an illegal mode or addressing r0 still take a grant slot
  function automatic logic f_dropped(input logic [2:0] mode, input logic [ADDR_W-1:0] addr);
    return (mode == c_MODE_NONE) || (mode > c_MODE_W32) || (addr == '0);
  endfunction

  assign w_drop0 = f_dropped(r_mode0, r_addr0);
  assign w_drop1 = f_dropped(r_mode1, r_addr1);

  assign w_g0 = r_full0 & (~r_full1 | r_last);
  assign w_g1 = r_full1 & (~r_full0 | ~r_last);

  assign p0_ready = ~r_full0 | w_g0;
  assign p1_ready = ~r_full1 | w_g1;
  assign w_acc0   = p0_valid & p0_ready;
  assign w_acc1   = p1_valid & p1_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full0 <= 1'b0;
      r_addr0 <= '0;
      r_mode0 <= c_MODE_NONE;
      r_data0 <= '0;
    end else if (w_acc0) begin
      r_full0 <= 1'b1;
      r_addr0 <= p0_addr;
      r_mode0 <= p0_mode;
      r_data0 <= p0_data;
    end else if (w_g0) begin
      r_full0 <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full1 <= 1'b0;
      r_addr1 <= '0;
      r_mode1 <= c_MODE_NONE;
      r_data1 <= '0;
    end else if (w_acc1) begin
      r_full1 <= 1'b1;
      r_addr1 <= p1_addr;
      r_mode1 <= p1_mode;
      r_data1 <= p1_data;
    end else if (w_g1) begin
      r_full1 <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we3  <= c_MODE_NONE;
      r_a3   <= '0;
      r_wd3  <= '0;
      r_last <= 1'b1;
    end else if (w_g0) begin
      r_we3  <= w_drop0 ? c_MODE_NONE : r_mode0;
      r_a3   <= r_addr0;
      r_wd3  <= r_data0;
      r_last <= 1'b0;
    end else if (w_g1) begin
      r_we3  <= w_drop1 ? c_MODE_NONE : r_mode1;
      r_a3   <= r_addr1;
      r_wd3  <= r_data1;
      r_last <= 1'b1;
    end else begin
      r_we3  <= c_MODE_NONE;
    end
  end

  // Dropped entries never reach here; r0 stays clear
  always_comb begin
    w_pend = '0;
    if (r_full0 && !w_drop0)     w_pend[r_addr0] = 1'b1;
    if (r_full1 && !w_drop1)     w_pend[r_addr1] = 1'b1;
    if (r_we3 != c_MODE_NONE)    w_pend[r_a3]    = 1'b1;
  end

  assign pend_mask  = w_pend;
  assign we3        = r_we3;
  assign a3         = r_a3;
  assign wd3        = r_wd3;
  assign last_grant = r_last;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_wb_arbiter
//  Purpose  : Directed and random self-checking bench for regfile_wb_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        p0_valid = 1'b0, p1_valid = 1'b0;
  logic        p0_ready, p1_ready;
  logic [4:0]  p0_addr = '0, p1_addr = '0;
  logic [2:0]  p0_mode = '0, p1_mode = '0;
  logic [31:0] p0_data = '0, p1_data = '0;
  logic [2:0]  we3;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic [31:0] pend_mask;
  logic        last_grant;

  int errors = 0;
  int checks = 0;

  regfile_wb_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_addr(p0_addr), .p0_mode(p0_mode), .p0_data(p0_data),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_addr(p1_addr), .p1_mode(p1_mode), .p1_data(p1_data),
    .we3(we3), .a3(a3), .wd3(wd3), .pend_mask(pend_mask), .last_grant(last_grant)
  );

  always #5 clk = ~clk;

  // Reference model: two one-entry slots, round-robin pointer, write stage
  bit          m_full[2];
  logic [4:0]  m_addr[2];
  logic [2:0]  m_mode[2];
  logic [31:0] m_data[2];
  bit          m_last;
  logic [2:0]  m_we3;
  logic [4:0]  m_a3;
  logic [31:0] m_wd3;
  logic [31:0] m_rf[32];
  logic [31:0] dut_rf[32];
  bit          rdy0, rdy1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_dropped(input logic [2:0] mode, input logic [4:0] addr);
    return !(mode inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd5}) || addr == 5'd0;
  endfunction

  function automatic int m_grant();
    if (m_full[0] && m_full[1]) return m_last ? 0 : 1;
    if (m_full[0]) return 0;
    if (m_full[1]) return 1;
    return -1;
  endfunction

  function automatic logic [31:0] m_pend();
    logic [31:0] m = '0;
    for (int p = 0; p < 2; p++)
      if (m_full[p] && !m_dropped(m_mode[p], m_addr[p])) m[m_addr[p]] = 1'b1;
    if (m_we3 != 3'd0) m[m_a3] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_full[p] = 0; m_addr[p] = '0; m_mode[p] = '0; m_data[p] = '0;
    end
    m_last = 1'b1; m_we3 = '0; m_a3 = '0; m_wd3 = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_we3", we3, 3'd0);
    chk("rst_a3", a3, 5'd0);
    chk("rst_wd3", wd3, 32'd0);
    chk("rst_pend", pend_mask, 32'd0);
    chk("rst_last", last_grant, 1'b1);
    chk("rst_rdy0", p0_ready, 1'b1);
    chk("rst_rdy1", p1_ready, 1'b1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // One clock: compare all outputs against the model mid-cycle, then advance both
  task automatic tick();
    int          g;
    bit          v[2], acc[2];
    logic [4:0]  ia[2];
    logic [2:0]  im[2];
    logic [31:0] id[2];
    @(negedge clk);
    g = m_grant();
    chk("p0_ready", p0_ready, !m_full[0] || g == 0);
    chk("p1_ready", p1_ready, !m_full[1] || g == 1);
    chk("we3", we3, m_we3);
    chk("a3", a3, m_a3);
    chk("wd3", wd3, m_wd3);
    chk("pend_mask", pend_mask, m_pend());
    chk("last_grant", last_grant, m_last);
    rdy0 = p0_ready;
    rdy1 = p1_ready;
    if (we3 != 3'd0) dut_rf[a3] = wd3;
    v[0] = p0_valid; ia[0] = p0_addr; im[0] = p0_mode; id[0] = p0_data;
    v[1] = p1_valid; ia[1] = p1_addr; im[1] = p1_mode; id[1] = p1_data;
    for (int p = 0; p < 2; p++) acc[p] = v[p] && (!m_full[p] || g == p);
    @(posedge clk);
    if (m_we3 != 3'd0) m_rf[m_a3] = m_wd3;
    if (g >= 0) begin
      m_we3  = m_dropped(m_mode[g], m_addr[g]) ? 3'd0 : m_mode[g];
      m_a3   = m_addr[g];
      m_wd3  = m_data[g];
      m_last = (g == 1);
    end else begin
      m_we3 = 3'd0;
    end
    for (int p = 0; p < 2; p++) begin
      if (acc[p]) begin
        m_full[p] = 1; m_addr[p] = ia[p]; m_mode[p] = im[p]; m_data[p] = id[p];
      end else if (g == p) begin
        m_full[p] = 0;
      end
    end
    #1;
  endtask

  initial begin
    int acc0, acc1;
    for (int r = 0; r < 32; r++) begin
      m_rf[r] = '0; dut_rf[r] = '0;
    end
    #2;
    do_reset();

    // single ALU write to r5
    p0_valid = 1; p0_addr = 5; p0_mode = 3'b101; p0_data = 32'hDEADBEEF;
    tick();
    p0_valid = 0;
    chk("t1_pend5_a", pend_mask[5], 1'b1);
    chk("t1_we3_idle", we3, 3'd0);
    tick();
    chk("t1_we3", we3, 3'b101);
    chk("t1_a3", a3, 5'd5);
    chk("t1_wd3", wd3, 32'hDEADBEEF);
    chk("t1_pend5_b", pend_mask[5], 1'b1);
    tick();
    chk("t1_pend5_c", pend_mask[5], 1'b0);
    chk("t1_we3_done", we3, 3'd0);

    // simultaneous requests, first tie after reset goes to port 0
    do_reset();
    p0_valid = 1; p0_addr = 3; p0_mode = 3'b101; p0_data = 32'h33;
    p1_valid = 1; p1_addr = 4; p1_mode = 3'b101; p1_data = 32'h44;
    tick();
    p0_valid = 0; p1_valid = 0;
    tick();
    chk("t2_first_a3", a3, 5'd3);
    chk("t2_first_we3", we3, 3'b101);
    tick();
    chk("t2_second_a3", a3, 5'd4);
    chk("t2_second_wd3", wd3, 32'h44);
    tick();
    chk("t2_idle_we3", we3, 3'd0);

    // both ports held valid: alternating grants, one accept per 2 cycles each
    do_reset();
    acc0 = 0; acc1 = 0;
    for (int k = 0; k < 9; k++) begin
      p0_valid = 1; p0_addr = 5'(10 + k); p0_mode = 3'b101; p0_data = 32'(k);
      p1_valid = 1; p1_addr = 5'(20 + k); p1_mode = 3'b101; p1_data = 32'(100 + k);
      tick();
      if (k > 0) begin
        acc0 += int'(rdy0);
        acc1 += int'(rdy1);
      end
    end
    p0_valid = 0; p1_valid = 0;
    chk("t3_acc0", acc0, 4);
    chk("t3_acc1", acc1, 4);
    repeat (4) tick();

    // dropped writes: r0 and illegal mode
    chk("t4_rdy0", p0_ready, 1'b1);
    chk("t4_rdy1", p1_ready, 1'b1);
    p1_valid = 1; p1_addr = 0; p1_mode = 3'b101; p1_data = 32'h1234;
    p0_valid = 1; p0_addr = 7; p0_mode = 3'b111; p0_data = 32'h5678;
    tick();
    p0_valid = 0; p1_valid = 0;
    repeat (4) begin
      chk("t4_we3", we3, 3'd0);
      chk("t4_pend0", pend_mask[0], 1'b0);
      chk("t4_pend7", pend_mask[7], 1'b0);
      tick();
    end

    // same address from both ports: later grant wins
    do_reset();
    p0_valid = 1; p0_addr = 9; p0_mode = 3'b101; p0_data = 32'd1;
    p1_valid = 1; p1_addr = 9; p1_mode = 3'b101; p1_data = 32'd2;
    tick();
    p0_valid = 0; p1_valid = 0;
    repeat (4) tick();
    chk("t5_r9", dut_rf[9], 32'd2);
    chk("t5_pend9", pend_mask[9], 1'b0);

    // reset mid-operation
    p0_valid = 1; p0_addr = 11; p0_mode = 3'b101; p0_data = 32'hAA;
    p1_valid = 1; p1_addr = 12; p1_mode = 3'b101; p1_data = 32'hBB;
    tick();
    p0_valid = 0; p1_valid = 0;
    tick();
    chk("t6_pre_we3", we3, 3'b101);
    chk("t6_pre_pend", pend_mask, (32'd1 << 11) | (32'd1 << 12));
    #2;
    rst = 1'b1;
    #1;
    chk("t6_we3", we3, 3'd0);
    chk("t6_pend", pend_mask, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) tick();
    chk("t6_r12", dut_rf[12], 32'd0);

    // random traffic against the model
    for (int k = 0; k < 300; k++) begin
      p0_valid = 1'($urandom_range(0, 1));
      p0_addr  = 5'($urandom_range(0, 31));
      p0_mode  = 3'($urandom_range(0, 7));
      p0_data  = $urandom;
      p1_valid = 1'($urandom_range(0, 1));
      p1_addr  = 5'($urandom_range(0, 31));
      p1_mode  = 3'($urandom_range(0, 7));
      p1_data  = $urandom;
      tick();
    end
    p0_valid = 0; p1_valid = 0;
    repeat (4) tick();
    for (int r = 0; r < 32; r++) chk($sformatf("rf_r%0d", r), dut_rf[r], m_rf[r]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
